ssram_target: RTL and testbench
===============================

Name: ssram_target

Overview:
- Bus responder for the 1M x 32 SSRAM region (chipselect 4'h6).
- Sits behind the bus controller. Consumes its start and buswrite strobes plus the CPU's read/write, and converts each bus cycle into a single-word pipelined SSRAM access.
- Returns read data and a ready flag that marks completion of the access.
- Both the read pipeline depth and the write recovery are handled here; the bus controller stays protocol-only.

Parameters:
- READ_LATENCY, 2, clocks from the SSRAM address strobe to valid sram_dq_in (legal 1..7).
- AW, 20, SSRAM word address width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- select  in  1  chipselect == 4'h6, decoded outside this block.
- read  in  1  CPU read request, held for the whole bus cycle.
- write  in  1  CPU write request, held for the whole bus cycle.
- start  in  1  address-latch pulse from the bus controller.
- buswrite  in  1  write-phase strobe from the bus controller.
- address  in  32  byte address; bits [AW+1:2] are used.
- be  in  4  byte enables, active-high.
- data_in  in  32  CPU write data.
- data_out  out  32  read data, held until the next read completes.
- ready  out  1  access complete; data_out is valid on reads.
- sram_addr  out  AW  registered word address.
- sram_adsc_n  out  1  address strobe, active-low, one-clock pulse.
- sram_we_n  out  1  write enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_be_n  out  4  byte lanes, active-low.
- sram_dq_out  out  32  write data.
- sram_dq_oe  out  1  data bus drive enable, 1 = drive.
- sram_dq_in  in  32  SSRAM read data.

Behaviour:
- All outputs are registered. Reset values:
  - state IDLE, ready 0, data_out 0, sram_addr 0.
  - sram_adsc_n 1, sram_we_n 1, sram_oe_n 1, sram_be_n 4'hF.
  - sram_dq_out 0, sram_dq_oe 0, latency counter 0.
- Reset is synchronous and wins over everything. Reset mid-access returns to IDLE and releases the bus next clock; no partial write is issued after reset.
- IDLE:
  - start && select && (read||write): latch sram_addr <= address[AW+1:2], sram_be_n <= ~be, and the direction (write wins if both are asserted).
  - A write goes to WWAIT. A read goes to RCMD.
  - start without select is ignored.
- WWAIT:
  - On buswrite: for exactly one clock drive sram_adsc_n=0, sram_we_n=0, sram_dq_oe=1, sram_dq_out=data_in. Next state is WREC.
  - If read and write both drop before buswrite: go to IDLE, no SSRAM write.
- WREC:
  - One clock with sram_dq_oe held 1 and sram_we_n/adsc_n at 1 (hold time), then DONE.
- RCMD:
  - sram_adsc_n=0 and sram_oe_n=0 for one clock.
  - Load the counter with READ_LATENCY-1 and go to RWAIT.
  - sram_oe_n stays 0 through RWAIT.
- RWAIT:
  - Decrement the counter each clock.
  - When the counter is 0: data_out <= sram_dq_in, sram_oe_n <= 1, go to DONE.
  - Total latency: the first RCMD clock to ready is READ_LATENCY+1 clocks.
  - If read drops during RWAIT: abandon, data_out unchanged, go to IDLE.
- DONE:
  - ready=1. Stay while read||write is asserted.
  - When both are low, go to IDLE with ready=0 on the next clock.
- Back-to-back cycles: a new start is honoured only in IDLE. A start arriving in any other state is ignored.
- sram_dq_oe and sram_oe_n are never both active. This is a checkable invariant.
- The block does no address range checking; out-of-range detection is the bus controller's job.

Optional Feature:
- Macro: SSRAM_POSTED_WRITE_EN.
- Defined: the WREC state is removed. The write completes WWAIT -> DONE directly, and ready is asserted the clock after the write strobe. sram_dq_oe still drops the clock after sram_we_n returns high.
- Undefined: the WREC recovery cycle is present and write ready comes 2 clocks after the strobe.

Test Plan:
- Reset held 3 clocks during an active read -> every output at its reset value; state IDLE; sram_dq_oe=0 and sram_oe_n=1 on the first post-reset clock.
- Write address 32'h00001234, be 4'b0011, data 32'hDEADBEEF, buswrite 1 clock after start -> one clock with sram_addr=20'h0048D, sram_be_n=4'b1100, we_n=0, adsc_n=0, dq_out=DEADBEEF; ready 2 clocks later (1 with SSRAM_POSTED_WRITE_EN).
- Read address 32'h003FFFFC, READ_LATENCY=2, SSRAM model returns 32'hCAFEF00D -> sram_addr=20'hFFFFF; ready and data_out=CAFEF00D exactly 3 clocks after the RCMD clock; held until read drops.
- Repeat the read with READ_LATENCY=1 and with READ_LATENCY=7 -> ready 2 and 8 clocks after RCMD respectively.
- Write abort (read and write drop in WWAIT before buswrite) and read abort (read drops in RWAIT) -> no we_n pulse, data_out keeps its prior value, IDLE next clock, ready never asserted.
- start with select=0, and a start during DONE -> no SSRAM strobes, state unchanged; the following valid cycle completes normally.

Source files
------------

// File: rtl/ssram_target.sv
// ssram_target: bus responder turning one CPU bus cycle into one pipelined SSRAM word access (1M x 32, chipselect 4'h6).
// Latency: read ready READ_LATENCY+1 clocks after the address-strobe clock; write ready 2 clocks after the write strobe (1 when posted).
// Backpressure: ready is held while read||write stays asserted; a new start is only accepted in IDLE, otherwise ignored.
// Optional feature: define SSRAM_POSTED_WRITE_EN to drop the write recovery state (write ready the clock after the strobe).
module ssram_target #(
    parameter int READ_LATENCY = 2,
    parameter int AW           = 20
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          select,
    input  logic          read,
    input  logic          write,
    input  logic          start,
    input  logic          buswrite,
    input  logic [31:0]   address,
    input  logic [3:0]    be,
    input  logic [31:0]   data_in,
    output logic [31:0]   data_out,
    output logic          ready,
    output logic [AW-1:0] sram_addr,
    output logic          sram_adsc_n,
    output logic          sram_we_n,
    output logic          sram_oe_n,
    output logic [3:0]    sram_be_n,
    output logic [31:0]   sram_dq_out,
    output logic          sram_dq_oe,
    input  logic [31:0]   sram_dq_in
);

    // WSTB is the clock on which the write strobe is visible on the pins;
    // WREC is the data hold clock after it.
`ifdef SSRAM_POSTED_WRITE_EN
    typedef enum logic [2:0] {IDLE, WWAIT, WSTB, RCMD, RWAIT, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, WWAIT, WSTB, WREC, RCMD, RWAIT, DONE} state_t;
`endif

    state_t     state;
    logic [2:0] lat_cnt;

    // Address bits outside the word index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address[31:AW+2], address[1:0]};

    // Access sequencer: every pin and status output is a register set on entry to the state that shows it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            ready       <= 1'b0;
            data_out    <= '0;
            sram_addr   <= '0;
            sram_adsc_n <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_be_n   <= 4'hF;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            lat_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    if (start && select && (read || write)) begin
                        sram_addr <= address[AW+1:2];
                        sram_be_n <= ~be;
                        if (write) begin
                            // Write wins when both directions are requested.
                            state <= WWAIT;
                        end else begin
                            sram_adsc_n <= 1'b0;
                            sram_oe_n   <= 1'b0;
                            state       <= RCMD;
                        end
                    end
                end

                WWAIT: begin
                    // A CPU that gave up before the write phase gets no SSRAM write.
                    if (!read && !write) begin
                        state <= IDLE;
                    end else if (buswrite) begin
                        sram_adsc_n <= 1'b0;
                        sram_we_n   <= 1'b0;
                        sram_dq_oe  <= 1'b1;
                        sram_dq_out <= data_in;
                        state       <= WSTB;
                    end
                end

                WSTB: begin
                    // Strobe lasts one clock; data keeps driving for hold time.
                    sram_adsc_n <= 1'b1;
                    sram_we_n   <= 1'b1;
`ifdef SSRAM_POSTED_WRITE_EN
                    ready       <= 1'b1;
                    state       <= DONE;
`else
                    state       <= WREC;
`endif
                end

`ifdef SSRAM_POSTED_WRITE_EN
                // Posted writes finish from WSTB; the bus is released in DONE.
`else
                WREC: begin
                    sram_dq_oe <= 1'b0;
                    ready      <= 1'b1;
                    state      <= DONE;
                end
`endif

                RCMD: begin
                    sram_adsc_n <= 1'b1;
                    lat_cnt     <= 3'(READ_LATENCY - 1);
                    state       <= RWAIT;
                end

                RWAIT: begin
                    if (!read) begin
                        // Abandoned read: leave data_out alone, release the bus.
                        sram_oe_n <= 1'b1;
                        lat_cnt   <= '0;
                        state     <= IDLE;
                    end else if (lat_cnt == 3'd0) begin
                        data_out  <= sram_dq_in;
                        sram_oe_n <= 1'b1;
                        ready     <= 1'b1;
                        state     <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end

                DONE: begin
                    // Posted writes still own the data bus for their first DONE clock.
                    sram_dq_oe <= 1'b0;
                    if (!read && !write) begin
                        ready <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ssram_target.sv
// tb_ssram_target: scoreboard bench for ssram_target at READ_LATENCY 2 (main), 1 and 7.
// Latency: checks ready timing per instance against READ_LATENCY+1 and the write recovery.
// Backpressure: holds read/write to exercise DONE holding, and issues ignored starts.
module tb_ssram_target;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        select   = 1'b0;
    logic        read     = 1'b0;
    logic        write    = 1'b0;
    logic        start    = 1'b0;
    logic        buswrite = 1'b0;
    logic [31:0] address  = '0;
    logic [3:0]  be       = '0;
    logic [31:0] data_in  = '0;

    logic [31:0] data_out_v [3];
    logic        ready_v    [3];
    logic [19:0] addr_v     [3];
    logic        adsc_v     [3];
    logic        we_v       [3];
    logic        oe_v       [3];
    logic [3:0]  be_n_v     [3];
    logic [31:0] dq_out_v   [3];
    logic        dq_oe_v    [3];
    logic [31:0] dq_in_v    [3];

    localparam int LAT [3] = '{2, 1, 7};

`ifdef SSRAM_POSTED_WRITE_EN
    localparam int WR_READY = 1;
`else
    localparam int WR_READY = 2;
`endif

    typedef struct packed {
        logic [19:0] addr;
        logic [3:0]  be_n;
        logic [31:0] dat;
    } wr_t;

    wr_t         wr_q [$];
    logic [31:0] rd_q [$];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ssram_target #(.READ_LATENCY(2), .AW(20)) u_l2 (
        .clock(clock), .reset(reset), .select(select), .read(read), .write(write),
        .start(start), .buswrite(buswrite), .address(address), .be(be), .data_in(data_in),
        .data_out(data_out_v[0]), .ready(ready_v[0]), .sram_addr(addr_v[0]),
        .sram_adsc_n(adsc_v[0]), .sram_we_n(we_v[0]), .sram_oe_n(oe_v[0]),
        .sram_be_n(be_n_v[0]), .sram_dq_out(dq_out_v[0]), .sram_dq_oe(dq_oe_v[0]),
        .sram_dq_in(dq_in_v[0])
    );

    ssram_target #(.READ_LATENCY(1), .AW(20)) u_l1 (
        .clock(clock), .reset(reset), .select(select), .read(read), .write(write),
        .start(start), .buswrite(buswrite), .address(address), .be(be), .data_in(data_in),
        .data_out(data_out_v[1]), .ready(ready_v[1]), .sram_addr(addr_v[1]),
        .sram_adsc_n(adsc_v[1]), .sram_we_n(we_v[1]), .sram_oe_n(oe_v[1]),
        .sram_be_n(be_n_v[1]), .sram_dq_out(dq_out_v[1]), .sram_dq_oe(dq_oe_v[1]),
        .sram_dq_in(dq_in_v[1])
    );

    ssram_target #(.READ_LATENCY(7), .AW(20)) u_l7 (
        .clock(clock), .reset(reset), .select(select), .read(read), .write(write),
        .start(start), .buswrite(buswrite), .address(address), .be(be), .data_in(data_in),
        .data_out(data_out_v[2]), .ready(ready_v[2]), .sram_addr(addr_v[2]),
        .sram_adsc_n(adsc_v[2]), .sram_we_n(we_v[2]), .sram_oe_n(oe_v[2]),
        .sram_be_n(be_n_v[2]), .sram_dq_out(dq_out_v[2]), .sram_dq_oe(dq_oe_v[2]),
        .sram_dq_in(dq_in_v[2])
    );

    // SSRAM read model: data is valid only during the clock it is due, garbage otherwise.
    int          mcnt [3] = '{0, 0, 0};
    logic [31:0] mdata    = '0;

    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (adsc_v[i] === 1'b0 && we_v[i] === 1'b1) mcnt[i] <= LAT[i];
            else if (mcnt[i] != 0)                        mcnt[i] <= mcnt[i] - 1;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            dq_in_v[i] = (mcnt[i] == 1) ? mdata : 32'h0BAD_BAD0;
        end
    end

    // Running event counters for the main instance, plus the bus-contention invariant on all.
    int strobe_seen = 0;
    int we_seen     = 0;
    int ready_seen  = 0;

    always @(negedge clock) begin
        if (adsc_v[0] === 1'b0) strobe_seen++;
        if (we_v[0] === 1'b0)   we_seen++;
        if (ready_v[0] === 1'b1) ready_seen++;
        if (reset === 1'b0) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dq_oe_v[i] === 1'b1 && oe_v[i] === 1'b0) begin
                    errors++;
                    $display("FAIL bus_contention inst%0d: dq_oe=%b oe_n=%b, required not both active", i, dq_oe_v[i], oe_v[i]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [92:0] got;
        logic [92:0] exp;
        exp = {1'b0, 32'h0, 20'h0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h0, 1'b0};
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        mdata = 32'h1234_5678;
        address = 32'h40; select = 1'b1; read = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            @(negedge clock);
            got = {ready_v[0], data_out_v[0], addr_v[0], adsc_v[0], we_v[0], oe_v[0],
                   be_n_v[0], dq_out_v[0], dq_oe_v[0]};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_outputs clk%0d: got %h required %h", k, got, exp);
            end
        end
        reset = 1'b0;
        read = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if ({dq_oe_v[0], oe_v[0], adsc_v[0], we_v[0], ready_v[0]} !== 5'b01110) begin
            errors++;
            $display("FAIL post_reset_bus: got dq_oe/oe_n/adsc_n/we_n/ready=%b required 01110",
                     {dq_oe_v[0], oe_v[0], adsc_v[0], we_v[0], ready_v[0]});
        end
        select = 1'b0;
        tick();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        wr_t e;
        bit  found;
        int  n;
        e.addr = a[21:2];
        e.be_n = ~b;
        e.dat  = d;
        wr_q.push_back(e);
        address = a; be = b; data_in = d; select = 1'b1; write = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; buswrite = 1'b1;
        tick();
        buswrite = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (we_v[0] === 1'b0) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL write_strobe_timeout: got no we_n pulse, required one");
        end else begin
            e = wr_q.pop_front();
            checks++;
            if (addr_v[0] !== e.addr) begin
                errors++;
                $display("FAIL write_addr: got %h required %h", addr_v[0], e.addr);
            end
            checks++;
            if (be_n_v[0] !== e.be_n) begin
                errors++;
                $display("FAIL write_be_n: got %b required %b", be_n_v[0], e.be_n);
            end
            checks++;
            if (dq_out_v[0] !== e.dat) begin
                errors++;
                $display("FAIL write_dq_out: got %h required %h", dq_out_v[0], e.dat);
            end
            checks++;
            if ({adsc_v[0], dq_oe_v[0], oe_v[0]} !== 3'b011) begin
                errors++;
                $display("FAIL write_strobe_pins: got adsc_n/dq_oe/oe_n=%b required 011",
                         {adsc_v[0], dq_oe_v[0], oe_v[0]});
            end
            n = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clock);
                n++;
                if (n == 1) begin
                    checks++;
                    if ({we_v[0], adsc_v[0], dq_oe_v[0]} !== 3'b111) begin
                        errors++;
                        $display("FAIL write_hold: got we_n/adsc_n/dq_oe=%b required 111",
                                 {we_v[0], adsc_v[0], dq_oe_v[0]});
                    end
                end
                if (ready_v[0] === 1'b1) break;
            end
            checks++;
            if (n != WR_READY) begin
                errors++;
                $display("FAIL write_ready_latency: got %0d clocks required %0d", n, WR_READY);
            end
            tick();
            @(negedge clock);
            checks++;
            if ({ready_v[0], dq_oe_v[0]} !== 2'b10) begin
                errors++;
                $display("FAIL write_done_hold: got ready/dq_oe=%b required 10", {ready_v[0], dq_oe_v[0]});
            end
        end
        write = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (ready_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL write_ready_release: got %b required 0", ready_v[0]);
        end
        select = 1'b0;
        tick();
    endtask

    task automatic do_read(input int idx, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] exp;
        bit          found;
        int          n;
        mdata = d;
        rd_q.push_back(d);
        address = a; select = 1'b1; read = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (adsc_v[idx] === 1'b0) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL read_cmd_timeout inst%0d: got no adsc_n pulse, required one", idx);
        end else begin
            checks++;
            if (addr_v[idx] !== a[21:2]) begin
                errors++;
                $display("FAIL read_addr inst%0d: got %h required %h", idx, addr_v[idx], a[21:2]);
            end
            n = 0;
            for (int k = 0; k < 16; k++) begin
                @(negedge clock);
                n++;
                if (ready_v[idx] === 1'b1) break;
            end
            checks++;
            if (n != LAT[idx] + 1) begin
                errors++;
                $display("FAIL read_latency inst%0d: got %0d clocks required %0d", idx, n, LAT[idx] + 1);
            end
            exp = rd_q.pop_front();
            checks++;
            if (data_out_v[idx] !== exp) begin
                errors++;
                $display("FAIL read_data inst%0d: got %h required %h", idx, data_out_v[idx], exp);
            end
            repeat (2) @(negedge clock);
            checks++;
            if (ready_v[idx] !== 1'b1 || data_out_v[idx] !== exp) begin
                errors++;
                $display("FAIL read_hold inst%0d: got ready=%b data=%h required 1 %h",
                         idx, ready_v[idx], data_out_v[idx], exp);
            end
        end
        read = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (ready_v[idx] !== 1'b0) begin
            errors++;
            $display("FAIL read_ready_release inst%0d: got %b required 0", idx, ready_v[idx]);
        end
        select = 1'b0;
        tick();
    endtask

    task automatic test_write();
        do_write(32'h0000_1234, 4'b0011, 32'hDEAD_BEEF);
    endtask

    task automatic test_read();
        do_read(0, 32'h003F_FFFC, 32'hCAFE_F00D);
    endtask

    task automatic test_read_latency();
        do_read(1, 32'h0000_0100, 32'h1111_1111);
        do_read(2, 32'h0000_0200, 32'h7777_7777);
    endtask

    task automatic test_write_abort();
        int we0;
        int rdy0;
        we0 = we_seen; rdy0 = ready_seen;
        address = 32'h0000_0500; be = 4'hF; data_in = 32'hBAAD_F00D;
        select = 1'b1; write = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        write = 1'b0;
        tick();
        buswrite = 1'b1;
        tick();
        buswrite = 1'b0;
        repeat (4) tick();
        checks++;
        if (we_seen != we0) begin
            errors++;
            $display("FAIL write_abort_we: got %0d we_n pulses required 0", we_seen - we0);
        end
        checks++;
        if (ready_seen != rdy0) begin
            errors++;
            $display("FAIL write_abort_ready: got %0d ready clocks required 0", ready_seen - rdy0);
        end
        select = 1'b0;
        do_write(32'h0000_0504, 4'b1010, 32'h0F0F_5555);
    endtask

    task automatic test_read_abort();
        int rdy0;
        int stb0;
        do_read(0, 32'h0000_0080, 32'h5A5A_1234);
        rdy0 = ready_seen; stb0 = strobe_seen;
        mdata = 32'hFFFF_0000;
        address = 32'h0000_0084; select = 1'b1; read = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        read = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (oe_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL read_abort_oe: got oe_n=%b required 1", oe_v[0]);
        end
        repeat (5) tick();
        checks++;
        if (ready_seen != rdy0) begin
            errors++;
            $display("FAIL read_abort_ready: got %0d ready clocks required 0", ready_seen - rdy0);
        end
        checks++;
        if (strobe_seen != stb0 + 1) begin
            errors++;
            $display("FAIL read_abort_strobes: got %0d adsc_n clocks required 1", strobe_seen - stb0);
        end
        checks++;
        if (data_out_v[0] !== 32'h5A5A_1234) begin
            errors++;
            $display("FAIL read_abort_data: got %h required 5a5a1234", data_out_v[0]);
        end
        select = 1'b0;
        tick();
    endtask

    task automatic test_ignored_start();
        int          stb0;
        bit          found;
        logic [31:0] exp;
        stb0 = strobe_seen;
        select = 1'b0; read = 1'b1; address = 32'h0000_0700; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        read = 1'b0;
        tick();
        checks++;
        if (strobe_seen != stb0) begin
            errors++;
            $display("FAIL unselected_start: got %0d adsc_n clocks required 0", strobe_seen - stb0);
        end
        mdata = 32'h600D_F00D;
        rd_q.push_back(32'h600D_F00D);
        select = 1'b1; read = 1'b1; address = 32'h0000_0010; start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (ready_v[0] === 1'b1) begin found = 1'b1; break; end
        end
        exp = rd_q.pop_front();
        checks++;
        if (!found || data_out_v[0] !== exp) begin
            errors++;
            $display("FAIL done_setup_read: got ready=%b data=%h required 1 %h", found, data_out_v[0], exp);
        end
        stb0 = strobe_seen;
        write = 1'b1; address = 32'h0000_0020; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        @(negedge clock);
        checks++;
        if (strobe_seen != stb0 || ready_v[0] !== 1'b1 || addr_v[0] !== 20'h00004) begin
            errors++;
            $display("FAIL start_in_done: got strobes=%0d ready=%b addr=%h required 0 1 00004",
                     strobe_seen - stb0, ready_v[0], addr_v[0]);
        end
        read = 1'b0; write = 1'b0; select = 1'b0;
        tick();
        tick();
        do_write(32'h0000_0030, 4'b0100, 32'h1357_9BDF);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        for (int k = 0; k < 3; k++) begin
            a = $urandom & 32'h003F_FFFC;
            d = $urandom;
            b = 4'($urandom_range(1, 15));
            do_write(a, b, d);
            do_read(0, a, d ^ 32'hA5A5_0000);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_read_latency();
        test_write_abort();
        test_read_abort();
        test_ignored_start();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
